// File: rtl/codec_adc_rx.sv
// WM8731 slave-mode ADC receiver: drives BCLK/ADCLRC, captures I2S ADCDAT, queues {left,right} words; push 1 cycle after last right bit, rd_data 1 cycle after rd_en.
// Full FIFO drops the newest word and sets ovf; with ADC_DROP_OLDEST_EN defined the oldest word is discarded instead.
module codec_adc_rx #(
  parameter int BCLK_DIV = 8,
  parameter int CH_BITS  = 16,
  parameter int FIFO_AW  = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               enable,
  output logic               adc_bclk,
  output logic               adc_lrc,
  input  logic               adc_dat,
  input  logic               rd_en,
  output logic [31:0]        rd_data,
  output logic               rd_valid,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               ovf,
  input  logic               ovf_clr
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int DW    = $clog2(BCLK_DIV);
  localparam logic [DW-1:0]    DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0]    DIV_ONE  = DW'(1);
  localparam logic [5:0]       PUSH_BIT = 6'(32 + CH_BITS);
  localparam logic [4:0]       K_LAST   = 5'(CH_BITS);
  localparam logic [FIFO_AW:0] PTR_ONE  = (FIFO_AW + 1)'(1);

  logic [DW-1:0]      div_cnt;
  logic [5:0]         bit_cnt;
  logic               dat_s1, dat_s2;
  logic [CH_BITS-1:0] left_sr, right_sr;
  logic               push_req;
  logic               tick, rise;
  logic [4:0]         k;
  logic [31:0]        word;

  assign tick    = (div_cnt == DIV_LAST);
  assign rise    = tick && !adc_bclk;
  assign k       = bit_cnt[4:0];
  assign adc_lrc = bit_cnt[5];
  assign word    = 32'({left_sr, right_sr});

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dat_s1 <= 1'b0;
      dat_s2 <= 1'b0;
    end else begin
      dat_s1 <= adc_dat;
      dat_s2 <= dat_s1;
    end
  end

  // bit_cnt only advances on BCLK falls, so ADCLRC always moves on a falling edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt  <= '0;
      adc_bclk <= 1'b0;
      bit_cnt  <= '0;
      left_sr  <= '0;
      right_sr <= '0;
      push_req <= 1'b0;
    end else if (!enable) begin
      div_cnt  <= '0;
      adc_bclk <= 1'b0;
      bit_cnt  <= '0;
      left_sr  <= '0;
      right_sr <= '0;
      push_req <= 1'b0;
    end else begin
      push_req <= rise && (bit_cnt == PUSH_BIT);
      if (tick) begin
        div_cnt  <= '0;
        adc_bclk <= !adc_bclk;
        if (adc_bclk) bit_cnt <= bit_cnt + 6'd1;
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
      // k=0 is the I2S one-bit delay slot; bits past CH_BITS are padding.
      if (rise && (k >= 5'd1) && (k <= K_LAST)) begin
        if (bit_cnt[5]) right_sr <= CH_BITS'({right_sr, dat_s2});
        else            left_sr  <= CH_BITS'({left_sr, dat_s2});
      end
    end
  end

  logic [31:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             push, pop, ovr, wr_acc, rd_adv;

  assign push       = push_req && enable;
  assign fifo_level = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = fifo_level[FIFO_AW];
  assign pop        = rd_en && !fifo_empty;
  assign ovr        = push && fifo_full && !pop;

`ifdef ADC_DROP_OLDEST_EN
  assign wr_acc = push;
  assign rd_adv = pop || ovr;
`else
  assign wr_acc = push && !ovr;
  assign rd_adv = pop;
`endif

  always_ff @(posedge sys_clk) begin
    if (wr_acc) mem[wr_ptr[FIFO_AW-1:0]] <= word;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop)    rd_data <= mem[rd_ptr[FIFO_AW-1:0]];
      if (wr_acc) wr_ptr  <= wr_ptr + PTR_ONE;
      if (rd_adv) rd_ptr  <= rd_ptr + PTR_ONE;
      if (ovr)          ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_codec_adc_rx.sv
// Bench for codec_adc_rx: I2S codec model driven from the DUT clocks, queue-based FIFO model, scoreboard monitor.
module tb_codec_adc_rx;
  logic        sys_clk = 1'b0;
  logic        sys_rst, enable, rd_en, ovf_clr;
  logic        adc_dat = 1'b0;
  logic        adc_bclk, adc_lrc, rd_valid, fifo_empty, fifo_full, ovf;
  logic [31:0] rd_data;
  logic [4:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  logic [31:0] tx_q[$];
  logic [31:0] mq[$];
  logic [31:0] expq[$];
  logic [31:0] cur = 32'h0;
  int          fc = 0;
  int          npush = 0;
  bit          prev_b = 1'b0, prev_run = 1'b0, model_ovf = 1'b0;

  codec_adc_rx dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
    .adc_bclk(adc_bclk), .adc_lrc(adc_lrc), .adc_dat(adc_dat),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] filler();
    return $urandom & 32'h7FFF_FFFF;
  endfunction

  // I2S frame: 64 BCLKs; in each 32-bit half, slot 0 is the delay bit, slots 1..16 carry MSB first.
  function automatic logic i2s_bit(input logic [31:0] w, input int pos);
    int k;
    k = pos % 32;
    if (k < 1 || k > 16) return 1'($urandom_range(0, 1));
    return (pos < 32) ? w[32-k] : w[16-k];
  endfunction

  task automatic model_push(input logic [31:0] w);
    npush++;
    if (mq.size() < 16) mq.push_back(w);
    else begin
      model_ovf = 1'b1;
`ifdef ADC_DROP_OLDEST_EN
      void'(mq.pop_front());
      mq.push_back(w);
`endif
    end
  endtask

  // Codec model: follows BCLK falls, changes data on them, and records each completed frame.
  always @(posedge sys_clk) begin
    #1;
    if (sys_rst || !enable) begin
      fc = 0;
      prev_run = 1'b0;
      prev_b = 1'b0;
      if (sys_rst) begin
        mq.delete();
        model_ovf = 1'b0;
      end
    end else begin
      if (!prev_run) begin
        fc = 0;
        cur = (tx_q.size() > 0) ? tx_q.pop_front() : filler();
        adc_dat = i2s_bit(cur, fc);
      end else if (prev_b && !adc_bclk) begin
        fc = (fc + 1) % 64;
        if (fc == 0) cur = (tx_q.size() > 0) ? tx_q.pop_front() : filler();
        if (fc == 49) model_push(cur);
        adc_dat = i2s_bit(cur, fc);
      end
      prev_run = 1'b1;
      prev_b = adc_bclk;
    end
  end

  always @(negedge sys_clk) begin
    if (!sys_rst && rd_valid) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: unexpected rd_valid with data %0h, nothing expected", rd_data);
      end else begin
        check("scoreboard", rd_data, expq.pop_front());
      end
    end
  end

  task automatic do_read(output logic [31:0] d, output bit got);
    @(negedge sys_clk);
    rd_en = 1'b1;
    if (mq.size() > 0) expq.push_back(mq.pop_front());
    @(negedge sys_clk);
    rd_en = 1'b0;
    got = rd_valid;
    d = rd_data;
  endtask

  task automatic wait_push(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (npush < target && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    total++;
    if (npush < target) begin
      bad++;
      $display("FAIL %s: timeout, pushes %0d expected %0d", name, npush, target);
    end
  endtask

  task automatic wait_fc(input int target, input string name);
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (fc != target && n < 3000);
    total++;
    if (fc != target) begin
      bad++;
      $display("FAIL %s: timeout, bit position %0d expected %0d", name, fc, target);
    end
  endtask

  task automatic wait_nonempty(output bit ok);
    int n;
    n = 0;
    while (mq.size() == 0 && n < 2500) begin
      @(negedge sys_clk);
      n++;
    end
    ok = (mq.size() > 0);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_word: timeout, got none expected one");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bclk"}, adc_bclk, 0);
    check({tag, "_lrc"}, adc_lrc, 0);
    check({tag, "_empty"}, fifo_empty, 1);
    check({tag, "_full"}, fifo_full, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, sent[12], ov[18];
    bit got, ok, found;
    bit pb, pl;
    int r1, r2, l1, l2, base;

    sys_rst = 1'b1; enable = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    repeat (10) @(negedge sys_clk);
    check_reset_outputs("reset");
    sys_rst = 1'b0;

    // Pop while empty: no pulse, rd_data holds.
    @(negedge sys_clk); rd_en = 1'b1;
    @(negedge sys_clk); rd_en = 1'b0;
    check("empty_pop_valid", rd_valid, 0);
    check("empty_pop_data", rd_data, 0);

    // Clock timing plus a single known sample.
    tx_q.push_back(32'hA5A5_3C3C);
    @(negedge sys_clk); enable = 1'b1;
    r1 = -1; r2 = -1; l1 = -1; l2 = -1;
    pb = adc_bclk; pl = adc_lrc;
    for (int i = 0; i < 1500 && l2 < 0; i++) begin
      @(negedge sys_clk);
      if (!pb && adc_bclk) begin
        if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
      end
      if (pl != adc_lrc) begin
        check("lrc_on_bclk_fall", {30'd0, pb, adc_bclk}, 32'd2);
        if (l1 < 0) l1 = i; else l2 = i;
      end
      pb = adc_bclk; pl = adc_lrc;
    end
    check("bclk_period", r2 - r1, 16);
    check("lrc_half_period", l2 - l1, 512);
    wait_push(1, 2000, "single_push");
    check("single_level", fifo_level, 1);
    do_read(d, got);
    check("single_valid", got, 1);
    check("single_data", d, 32'hA5A5_3C3C);
    @(negedge sys_clk);
    check("valid_is_pulse", rd_valid, 0);

    // Stream: sync word then 12 random words; master polls for the sync.
    tx_q.push_back(32'hFFFF_AAAA);
    foreach (sent[i]) begin
      sent[i] = $urandom;
      tx_q.push_back(sent[i]);
    end
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      wait_nonempty(ok);
      if (!ok) break;
      do_read(d, got);
      if (got && d == 32'hFFFF_AAAA) found = 1'b1;
    end
    check("stream_sync_found", found, 1);
    foreach (sent[i]) begin
      wait_nonempty(ok);
      do_read(d, got);
      check("stream_valid", got, 1);
      check("stream_word", d, sent[i]);
    end

    // Drop enable at bit 40 for 5 cycles: the partial word must vanish.
    wait_fc(30, "drain_point");
    while (mq.size() > 0) do_read(d, got);
    wait_fc(40, "drop_point");
    enable = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("drop_empty", fifo_empty, 1);
    check("drop_level", fifo_level, 0);
    check("drop_bclk", adc_bclk, 0);
    check("drop_lrc", adc_lrc, 0);
    d = filler();
    tx_q.push_back(d);
    sent[0] = d;
    base = npush;
    enable = 1'b1;
    wait_push(base + 1, 2000, "reenable_push");
    check("reenable_level", fifo_level, 1);
    do_read(d, got);
    check("reenable_word", d, sent[0]);

    // Reset mid-frame with a word stored.
    wait_push(npush + 1, 2000, "pre_reset_push");
    wait_fc(20, "reset_point");
    sys_rst = 1'b1;
    #1;
    expq.delete();
    check_reset_outputs("midreset");
    enable = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_reset_outputs("post_reset");

    // Overflow: 18 frames, no reads.
    foreach (ov[i]) begin
      ov[i] = filler();
      tx_q.push_back(ov[i]);
    end
    base = npush;
    enable = 1'b1;
    wait_push(base + 18, 20000, "ovf_frames");
    enable = 1'b0;
    @(negedge sys_clk);
    check("ovf_full", fifo_full, 1);
    check("ovf_flag", ovf, 1);
    check("ovf_model", ovf, model_ovf);
    check("ovf_level", fifo_level, 16);
    for (int i = 0; i < 16; i++) begin
      do_read(d, got);
`ifdef ADC_DROP_OLDEST_EN
      check("ovf_pop", d, ov[i+2]);
`else
      check("ovf_pop", d, ov[i]);
`endif
    end
    @(negedge sys_clk);
    check("ovf_drained", fifo_empty, 1);
    check("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    @(negedge sys_clk);
    ovf_clr = 1'b0;
    model_ovf = 1'b0;
    @(negedge sys_clk);
    check("ovf_clr", ovf, 0);
    check("queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
